alu_seq: RTL and testbench

//   Parametrised, handshaked successor to the 32-bit combinational ALU.

---
 rtl/alu_seq.sv | 200 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
//   Handshaked sequential ALU. One operation is accepted per valid/ready
//   transaction; logic/arithmetic ops produce a registered result one edge
//   after acceptance, MUL runs as an iterative shift-add over WIDTH cycles.
//   The result and N/Z/C/V/illegal flags are held until the consumer takes
//   them with out_ready.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operation present on a/b/op
//   in_ready   block can accept an operation this cycle (combinational)
//   a, b       operands (shift amount = b[SHW-1:0])
//   op         0 ADD 1 SUB 2 OR 3 AND 4 NOR 5 SLT 6 SLTU 7 SLL 8 SRL 9 SRA 10 MUL
//   out_valid  res/flags valid
//   out_ready  consumer takes the result this cycle
//   res        result
//   n, z, c, v negative, zero, carry, overflow
//   illegal    op 11..15 was issued
// -----------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             n,
    output logic             z,
    output logic             c,
    output logic             v,
    output logic             illegal
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;          // counter must hold WIDTH itself
    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_OR   = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_NOR  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SLTU = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic             accept;
    logic             is_mul;

    // single-cycle datapath
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic             alu_ill;
    logic [SHW-1:0]   shamt;

    // iterative multiplier
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;

    assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
    assign out_valid = (state == DONE);
    assign accept    = in_valid & in_ready;
    assign is_mul    = (op == OP_MUL);
    assign shamt     = b[SHW-1:0];

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of the others regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every combinational output gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid) state_nxt = is_mul ? MUL : DONE;
            end
            MUL: begin
                if (count == '0) state_nxt = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    if (in_valid) state_nxt = is_mul ? MUL : DONE;
                    else          state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One-cycle ALU evaluated straight off the input operands; its result is
    // only registered on an accepting edge.
    always_comb begin
        sum     = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ill = 1'b0;
        case (op)
            OP_ADD: begin
                sum     = {1'b0, a} + {1'b0, b};
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a[MSB] == b[MSB]) & (alu_res[MSB] != a[MSB]);
            end
            OP_SUB: begin
                // c=1 means no borrow
                sum     = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a[MSB] != b[MSB]) & (alu_res[MSB] != a[MSB]);
            end
            OP_OR:   alu_res = a | b;
            OP_AND:  alu_res = a & b;
            OP_NOR:  alu_res = ~(a | b);
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL:  alu_res = a << shamt;
            OP_SRL:  alu_res = a >> shamt;
            OP_SRA:  alu_res = $signed(a) >>> shamt;
            OP_MUL:  alu_res = '0;      // handled by the iterative path
            default: alu_ill = 1'b1;    // res=0 gives z=1
        endcase
    end

    // NOTE: the multiplier working registers are reset along with the
    // result so a reset mid-MUL leaves no partial product behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res     <= '0;
            n       <= 1'b0;
            z       <= 1'b0;
            c       <= 1'b0;
            v       <= 1'b0;
            illegal <= 1'b0;
            count   <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
        end else if (accept) begin
            if (is_mul) begin
                count   <= CW'(WIDTH);
                acc     <= '0;
                mcand   <= a;
                mplier  <= b;
                illegal <= 1'b0;
            end else begin
                res     <= alu_res;
                n       <= alu_res[MSB];
                z       <= (alu_res == '0);
                c       <= alu_c;
                v       <= alu_v;
                illegal <= alu_ill;
            end
        end else if (state == MUL) begin
            if (count == '0) begin
                res <= acc;
                n   <= acc[MSB];
                z   <= (acc == '0);
                c   <= 1'b0;
                v   <= 1'b0;
            end else begin
                if (mplier[0]) acc <= acc + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                count  <= count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq
//   Scoreboard bench for alu_seq (WIDTH=32). The stimulus side pushes the
//   reference-model response when an operation is accepted; an independent
//   monitor pops and compares whenever a result is handed over.
// -----------------------------------------------------------------------------
module tb_alu_seq;

    localparam int W = 32;

    localparam logic [3:0] ADD  = 4'd0;
    localparam logic [3:0] SUB  = 4'd1;
    localparam logic [3:0] OR_  = 4'd2;
    localparam logic [3:0] AND_ = 4'd3;
    localparam logic [3:0] NOR_ = 4'd4;
    localparam logic [3:0] SLT  = 4'd5;
    localparam logic [3:0] SLTU = 4'd6;
    localparam logic [3:0] SLL  = 4'd7;
    localparam logic [3:0] SRL  = 4'd8;
    localparam logic [3:0] SRA  = 4'd9;
    localparam logic [3:0] MUL  = 4'd10;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] a        = '0;
    logic [W-1:0] b        = '0;
    logic [3:0]   op       = '0;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] res;
    logic         n, z, c, v, illegal;

    logic bp_rand   = 1'b0;
    logic or_manual = 1'b1;
    logic rand_bit  = 1'b1;

    int checks   = 0;
    int failures = 0;

    // expected {res, n, z, c, v, illegal}
    logic [36:0] sb[$];
    logic [36:0] mon_e;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .n         (n),
        .z         (z),
        .c         (c),
        .v         (v),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        rand_bit = ($urandom_range(0, 3) != 0);
    end

    assign out_ready = bp_rand ? rand_bit : or_manual;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on 64-bit values.
    function automatic logic [36:0] model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] r;
        logic   cc, vv, ill;
        longint sx, sy, ux, uy;
        int     sh;
        r   = '0;
        cc  = 1'b0;
        vv  = 1'b0;
        ill = 1'b0;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        ux  = longint'(x);
        uy  = longint'(y);
        sh  = int'(y[4:0]);
        case (o)
            ADD: begin
                r  = x + y;
                cc = (ux + uy) > longint'(32'hFFFF_FFFF);
                vv = ((sx + sy) > SMAX) || ((sx + sy) < SMIN);
            end
            SUB: begin
                r  = x - y;
                cc = (ux >= uy);
                vv = ((sx - sy) > SMAX) || ((sx - sy) < SMIN);
            end
            OR_:  r = x | y;
            AND_: r = x & y;
            NOR_: r = ~(x | y);
            SLT:  r = (sx < sy) ? 32'd1 : 32'd0;
            SLTU: r = (ux < uy) ? 32'd1 : 32'd0;
            SLL:  r = x << sh;
            SRL:  r = x >> sh;
            SRA:  r = 32'(sx >>> sh);
            MUL:  r = 32'(ux * uy);
            default: ill = 1'b1;
        endcase
        return {r, r[31], (r == '0), cc, vv, ill};
    endfunction

    function automatic logic [W-1:0] rnd_opnd();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: compares every result handed to the consumer.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("result", {27'b0, res, n, z, c, v, illegal}, {27'b0, mon_e});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Call at posedge+1. Returns at posedge+1 just after the accepting edge.
    task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        int w;
        w        = 0;
        op       = o;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            check("issue_timeout", 64'(in_ready), 64'd1);
        end else begin
            sb.push_back(model(o, x, y));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 500) begin
            @(posedge clk);
            w++;
        end
        #1;
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int busy_bad;
        logic [36:0] hold_e;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_res_flags", {27'b0, res, n, z, c, v, illegal}, 64'd0);
        rst_n = 1'b1;
        step();

        // basic arithmetic and single-edge latency
        issue(ADD, 32'd1, 32'd2);
        @(negedge clk);
        check("add_latency", 64'(out_valid), 64'd1);
        step();
        issue(SUB, 32'd1, 32'd2);
        issue(ADD, 32'h7FFF_FFFF, 32'd1);
        issue(SUB, 32'd5, 32'd5);
        issue(SLT, 32'hFFFF_FFFF, 32'd1);
        issue(SLTU, 32'hFFFF_FFFF, 32'd1);
        issue(SRA, 32'h8000_0000, 32'd4);
        issue(SLL, 32'h4000_0001, 32'd33);
        issue(NOR_, 32'hF0F0_0000, 32'h0000_000F);
        drain();

        // MUL latency: out_valid appears WIDTH+1 edges after accept
        issue(MUL, 32'd3, 32'd5);
        cyc      = 0;
        busy_bad = 0;
        forever begin
            @(negedge clk);
            if (out_valid || cyc > 100) break;
            if (in_ready) busy_bad++;
            @(posedge clk);
            cyc++;
        end
        check("mul_latency", 64'(cyc), 64'(W + 1));
        check("mul_busy_in_ready", 64'(busy_bad), 64'd0);
        step();
        issue(MUL, 32'hFFFF_FFFF, 32'd2);
        drain();

        // backpressure: result held, no acceptance, then no-bubble handoff
        or_manual = 1'b0;
        issue(ADD, 32'h7FFF_FFFF, 32'd1);
        hold_e = model(ADD, 32'h7FFF_FFFF, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_hold", {27'b0, res, n, z, c, v, illegal}, {27'b0, hold_e});
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        step();
        or_manual = 1'b1;
        issue(OR_, 32'h0F0F_0000, 32'h0000_00F0);
        @(negedge clk);
        check("no_bubble", 64'(out_valid), 64'd1);
        step();
        drain();

        // asynchronous reset in the middle of a MUL
        issue(MUL, 32'h0001_2345, 32'h0000_0678);
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midmul_rst_out_valid", 64'(out_valid), 64'd0);
        check("midmul_rst_res", 64'(res), 64'd0);
        check("midmul_rst_in_ready", 64'(in_ready), 64'd1);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        issue(ADD, 32'd1, 32'd2);
        issue(4'd12, 32'hDEAD_BEEF, 32'h1234_5678);
        issue(ADD, 32'd3, 32'd4);
        issue(MUL, 32'd7, 32'd9);
        drain();

        // randomized traffic with random backpressure
        bp_rand = 1'b1;
        for (int i = 0; i < 300; i++) begin
            issue(4'($urandom_range(0, 15)), rnd_opnd(), rnd_opnd());
            if ($urandom_range(0, 3) == 0) step();
        end
        bp_rand = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
